// File: rtl/usart_pkg.sv
// Shared definitions for the UART frame transmitter and its request scheduler.
package usart_pkg;

  localparam int unsigned TX_NUM = 5;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned MOD_W  = 6;
  localparam int unsigned DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after i_last (modulo NREQ) wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  // Walk from the lowest priority (i_last itself) up to i_last+1 so the nearest hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % int'(NREQ)]) begin
        o_gnt   = '0;
        o_gnt[(int'(i_last) + k) % int'(NREQ)] = 1'b1;
        o_idx   = PW'((int'(i_last) + k) % int'(NREQ));
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usart_tx_sched.sv
// Shares one 5-byte UART frame transmitter between NREQ requesters; frame completion is
// timed locally because the transmitter reports neither busy nor done.
module usart_tx_sched
  import usart_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned TRIG_CYCLES  = 4,
  parameter int unsigned FRAME_CYCLES = 32000,
  localparam int unsigned PW          = $clog2(NREQ)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NREQ-1:0]          req,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [MOD_W*NREQ-1:0]    req_mod,
  input  logic [DATA_W*NREQ-1:0]   req_d,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic                     tx_trig,
  output logic [ADDR_W-1:0]        tx_addr,
  output logic [MOD_W-1:0]         tx_mod,
  output logic [DATA_W-1:0]        tx_d
);

  if (NREQ < 2 || NREQ > 8 || TRIG_CYCLES < 2 || FRAME_CYCLES > 65535 ||
      FRAME_CYCLES <= TRIG_CYCLES) begin : g_param_err
    $error("usart_tx_sched: illegal parameter combination");
  end

  localparam logic [15:0] TrigEnd  = 16'(TRIG_CYCLES);
  localparam logic [15:0] FrameEnd = 16'(FRAME_CYCLES);

  sched_state_t        r_state, w_state_d;
  logic [15:0]         r_timer, w_timer_d;
  logic [PW-1:0]       r_ptr, w_ptr_d;
  logic [NREQ-1:0]     r_ack, w_ack_d;
  logic                r_busy, w_busy_d;
  logic                r_trig, w_trig_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [MOD_W-1:0]    r_mod, w_mod_d;
  logic [DATA_W-1:0]   r_d, w_d_d;

  logic [NREQ-1:0]     w_gnt;
  logic [PW-1:0]       w_idx;
  logic                w_valid;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (req),
    .i_last  (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_ptr_d   = r_ptr;
    w_ack_d   = '0;
    w_busy_d  = r_busy;
    w_trig_d  = r_trig;
    w_addr_d  = r_addr;
    w_mod_d   = r_mod;
    w_d_d     = r_d;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_d = TRIG;
          w_timer_d = 16'd1;
          w_ptr_d   = w_idx;
          w_ack_d   = w_gnt;
          w_busy_d  = 1'b1;
          w_trig_d  = 1'b1;
          w_addr_d  = req_addr[w_idx*ADDR_W +: ADDR_W];
          w_mod_d   = req_mod[w_idx*MOD_W +: MOD_W];
          w_d_d     = req_d[w_idx*DATA_W +: DATA_W];
        end
      end
      TRIG: begin
        w_timer_d = r_timer + 16'd1;
        if (r_timer == TrigEnd) begin
          w_trig_d  = 1'b0;
          w_state_d = WAIT;
        end
      end
      WAIT: begin
        if (r_timer == FrameEnd) begin
          w_timer_d = '0;
          w_busy_d  = 1'b0;
          w_state_d = IDLE;
        end else begin
          w_timer_d = r_timer + 16'd1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_ptr   <= PW'(NREQ - 1);
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_trig  <= 1'b0;
      r_addr  <= '0;
      r_mod   <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_ptr   <= w_ptr_d;
      r_ack   <= w_ack_d;
      r_busy  <= w_busy_d;
      r_trig  <= w_trig_d;
      r_addr  <= w_addr_d;
      r_mod   <= w_mod_d;
      r_d     <= w_d_d;
    end
  end

  assign ack     = r_ack;
  assign busy    = r_busy;
  assign tx_trig = r_trig;
  assign tx_addr = r_addr;
  assign tx_mod  = r_mod;
  assign tx_d    = r_d;

endmodule

// File: tb/tb_usart_tx_sched.sv
// Directed and randomized bench for usart_tx_sched against a frame-counting reference model.
module tb_usart_tx_sched;
  import usart_pkg::*;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned TRIGC  = 4;
  localparam int unsigned FRAMEC = 100;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_addr;
  logic [6*NREQ-1:0] req_mod;
  logic [24*NREQ-1:0] req_d;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              tx_trig;
  logic [1:0]        tx_addr;
  logic [5:0]        tx_mod;
  logic [23:0]       tx_d;

  always #5 sys_clk = ~sys_clk;

  usart_tx_sched #(
    .NREQ         (NREQ),
    .TRIG_CYCLES  (TRIGC),
    .FRAME_CYCLES (FRAMEC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .req_addr (req_addr),
    .req_mod  (req_mod),
    .req_d    (req_d),
    .ack      (ack),
    .busy     (busy),
    .tx_trig  (tx_trig),
    .tx_addr  (tx_addr),
    .tx_mod   (tx_mod),
    .tx_d     (tx_d)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: m_cnt = cycles elapsed since the current grant (0 = free to grant).
  int          m_cnt  = 0;
  int          m_last = NREQ - 1;
  logic [3:0]  m_ack  = '0;
  logic [1:0]  m_addr = '0;
  logic [5:0]  m_mod  = '0;
  logic [23:0] m_d    = '0;

  bit   hold_mode = 1'b0;
  bit   seen_ack3 = 1'b0;
  logic prev_trig = 1'b0;
  int   rise_q[$];
  int   grant_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_field(input int i, input logic [1:0] a, input logic [5:0] m,
                           input logic [23:0] d);
    req_addr[2*i +: 2]   = a;
    req_mod[6*i +: 6]    = m;
    req_d[24*i +: 24]    = d;
  endtask

  task automatic tick();
    logic [3:0]   s_req  = req;
    logic         s_rst  = sys_rst;
    logic [7:0]   s_addr = req_addr;
    logic [23:0]  s_mod  = req_mod;
    logic [95:0]  s_d    = req_d;
    bit           found  = 1'b0;
    @(posedge sys_clk);
    #1;
    cyc++;
    m_ack = '0;
    if (s_rst) begin
      m_cnt = 0; m_last = NREQ - 1; m_addr = '0; m_mod = '0; m_d = '0;
    end else if (m_cnt == 0) begin
      for (int k = 1; k <= int'(NREQ); k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (!found && s_req[i]) begin
          found  = 1'b1;
          m_last = i;
          m_ack  = 4'(1 << i);
          m_addr = s_addr[2*i +: 2];
          m_mod  = s_mod[6*i +: 6];
          m_d    = s_d[24*i +: 24];
          m_cnt  = 1;
        end
      end
    end else begin
      m_cnt = (m_cnt == int'(FRAMEC)) ? 0 : m_cnt + 1;
    end
    chk("ack", 32'(ack), 32'(m_ack));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("tx_trig", 32'(tx_trig), 32'(m_cnt >= 1 && m_cnt <= int'(TRIGC)));
    chk("tx_addr", 32'(tx_addr), 32'(m_addr));
    chk("tx_mod", 32'(tx_mod), 32'(m_mod));
    chk("tx_d", 32'(tx_d), 32'(m_d));
    if (tx_trig && !prev_trig) rise_q.push_back(cyc);
    prev_trig = tx_trig;
    for (int i = 0; i < int'(NREQ); i++) if (ack[i]) grant_q.push_back(i);
    if (ack[3]) seen_ack3 = 1'b1;
    if (!hold_mode) req = req & ~m_ack;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_idle();
    int b = 0;
    while (busy && b < int'(FRAMEC) + 10) begin
      tick();
      b++;
    end
    chk("idle_reach", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req     = '0;
    tick();
    tick();
    sys_rst   = 1'b0;
    hold_mode = 1'b0;
    seen_ack3 = 1'b0;
    rise_q.delete();
    grant_q.delete();
  endtask

  initial begin
    sys_rst  = 1'b1;
    req      = '0;
    req_addr = '0;
    req_mod  = '0;
    req_d    = '0;
    do_reset();

    // Single request, field capture and transmitted byte order.
    set_field(0, 2'b10, 6'h15, 24'hA5B6C7);
    req = 4'b0001;
    tick();
    chk("single_ack", 32'(ack), 32'h1);
    chk("byte0", 32'({6'b0, tx_addr}), 32'h02);
    chk("byte1", 32'({2'b0, tx_mod}), 32'h15);
    chk("byte2", 32'(tx_d[23:16]), 32'hA5);
    chk("byte3", 32'(tx_d[15:8]), 32'hB6);
    chk("byte4", 32'(tx_d[7:0]), 32'hC7);
    set_field(0, 2'b01, 6'h2A, 24'h123456);
    run(int'(FRAMEC) - 1);
    chk("busy_last", 32'(busy), 32'd1);
    tick();
    chk("busy_fall", 32'(busy), 32'd0);
    chk("d_hold", 32'(tx_d), 32'hA5B6C7);
    chk("single_rises", 32'(rise_q.size()), 32'd1);

    // Two simultaneous requesters held high.
    do_reset();
    hold_mode = 1'b1;
    req = 4'b0101;
    run(3 * (int'(FRAMEC) + 1));
    chk("simul_n", 32'(grant_q.size()), 32'd3);
    if (grant_q.size() == 3) begin
      chk("simul_g0", 32'(grant_q[0]), 32'd0);
      chk("simul_g1", 32'(grant_q[1]), 32'd2);
      chk("simul_g2", 32'(grant_q[2]), 32'd0);
    end

    // Fairness with every requester held high.
    do_reset();
    hold_mode = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) set_field(i, 2'(i), 6'(i + 8), 24'($urandom));
    req = 4'b1111;
    run(5 * (int'(FRAMEC) + 1));
    chk("fair_n", 32'(grant_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < grant_q.size(); i++) chk("fair_order", 32'(grant_q[i]), 32'(i % 4));
    for (int i = 1; i < rise_q.size(); i++)
      chk("fair_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'(FRAMEC + 1));

    // Reset in the middle of the wait phase.
    do_reset();
    hold_mode = 1'b1;
    set_field(1, 2'b11, 6'h3C, 24'hDEAD01);
    req = 4'b0010;
    run(50);
    sys_rst = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trig", 32'(tx_trig), 32'd0);
    chk("rst_d", 32'(tx_d), 32'd0);
    sys_rst = 1'b0;
    tick();
    chk("rst_reack", 32'(ack), 32'h2);
    hold_mode = 1'b0;
    req = '0;
    run_idle();

    // Requester 3 only asserts while the block is busy, so it must never be served.
    do_reset();
    req = 4'b0001;
    tick();
    run(10);
    req[3] = 1'b1;
    run(20);
    req[3] = 1'b0;
    run_idle();
    run(5);
    chk("drop_no_ack3", 32'(seen_ack3), 32'd0);

    // Randomized traffic with hold-until-ack requesters and occasional drops.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(NREQ); i++) set_field(i, 2'($urandom), 6'($urandom), 24'($urandom));
      if ($urandom_range(0, 7) == 0) req = req | 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) req[$urandom_range(0, 3)] = 1'b0;
      tick();
    end
    chk("rand_grants", 32'(grant_q.size() > 5), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
